// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_arbiter
// Purpose  : Round-robin scheduler sharing one I2C master engine among
//            NUM_REQ requesters. Grants one single-byte write at a time,
//            latches its fields, pulses the master enable, holds the fields
//            until the master reports done, then pulses req_done back to the
//            owning requester.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/ready     - per-requester handshake (ready one-hot)
//            req_dev_addr        - 7 bits per requester, slice i = requester i
//            req_data_addr       - 8 bits per requester
//            req_wdata           - 8 bits per requester
//            req_done/req_err    - one-cycle completion / error pulses
//            m_i2c_en            - one-cycle enable pulse to the master
//            m_device_addr/m_data_addr/m_write_data - latched fields
//            m_done_flag         - master transaction complete
//            busy                - high whenever the FSM is not idle
// Options  : I2C_ARB_TIMEOUT_EN  - builds a WAIT-state watchdog of
//            TIMEOUT_CYCLES cycles that completes the transaction with
//            req_err set; when undefined req_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [7*NUM_REQ-1:0]   req_dev_addr,
  input  logic [8*NUM_REQ-1:0]   req_data_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  output logic                   m_i2c_en,
  output logic [6:0]             m_device_addr,
  output logic [7:0]             m_data_addr,
  output logic [7:0]             m_write_data,
  input  logic                   m_done_flag,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] sel;
  logic             any_valid;
  logic             timeout_hit;
  int               idx;

  // Rotating priority search: first valid index at or above ptr, wrapping.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        sel       = IDX_W'(idx);
      end
    end
  end

  // Ready is masked while rst is high so no requester sees a handshake
  // that the reset is about to discard.
  assign req_ready = (state == S_IDLE && !rst && any_valid) ? (ONE_HOT0 << sel) : '0;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counter is zero in the first WAIT cycle, so reaching TIMEOUT_CYCLES-1
  // without done means the next edge is the TIMEOUT_CYCLES-th WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst)                 wait_cnt <= '0;
    else if (state == S_ISSUE) wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      req_err <= '0;
    end else begin
      req_err <= '0;
      if (state == S_WAIT && !m_done_flag && timeout_hit)
        req_err <= ONE_HOT0 << gnt;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
  assign req_err            = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_valid) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (m_done_flag || timeout_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      gnt           <= '0;
      m_i2c_en      <= 1'b0;
      m_device_addr <= '0;
      m_data_addr   <= '0;
      m_write_data  <= '0;
      req_done      <= '0;
      busy          <= 1'b0;
    end else begin
      m_i2c_en <= 1'b0;
      req_done <= '0;
      busy     <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            gnt           <= sel;
            m_device_addr <= req_dev_addr[sel*7 +: 7];
            m_data_addr   <= req_data_addr[sel*8 +: 8];
            m_write_data  <= req_wdata[sel*8 +: 8];
            m_i2c_en      <= 1'b1;  // high exactly while in ISSUE
          end
        end
        S_WAIT: begin
          if (m_done_flag || timeout_hit) req_done <= ONE_HOT0 << gnt;
        end
        S_DONE: begin
          ptr <= (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_arbiter
// Purpose  : Directed self-checking bench for i2c_master_arbiter (NUM_REQ=4).
//            Covers reset, single request, round robin, withdraw/late
//            arrival, mid-transaction reset and, when I2C_ARB_TIMEOUT_EN is
//            defined, the WAIT watchdog (TIMEOUT_CYCLES=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [7*N-1:0] req_dev_addr;
  logic [8*N-1:0] req_data_addr;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_done;
  logic [N-1:0]   req_err;
  logic           m_i2c_en;
  logic [6:0]     m_device_addr;
  logic [7:0]     m_data_addr;
  logic [7:0]     m_write_data;
  logic           m_done_flag;
  logic           busy;

  int tests_run    = 0;
  int tests_failed = 0;

  i2c_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_dev_addr  (req_dev_addr),
    .req_data_addr (req_data_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .req_done      (req_done),
    .req_err       (req_err),
    .m_i2c_en      (m_i2c_en),
    .m_device_addr (m_device_addr),
    .m_data_addr   (m_data_addr),
    .m_write_data  (m_write_data),
    .m_done_flag   (m_done_flag),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic set_fields(input int i, input logic [6:0] d, input logic [7:0] a, input logic [7:0] w);
    req_dev_addr[i*7 +: 7]  = d;
    req_data_addr[i*8 +: 8] = a;
    req_wdata[i*8 +: 8]     = w;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 4'b1111; m_done_flag = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if ({req_ready, req_done, req_err, m_i2c_en, busy} !== 15'd0 ||
          {m_device_addr, m_data_addr, m_write_data} !== 23'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs: ready=%b done=%b err=%b en=%b busy=%b dev=%h addr=%h data=%h, required all zero",
                 req_ready, req_done, req_err, m_i2c_en, busy, m_device_addr, m_data_addr, m_write_data);
      end
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b required 0001", req_ready);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_single;
    logic bad;
    set_fields(2, 7'h50, 8'h10, 8'hA5);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++; $display("FAIL single_ready: got %b required 0100", req_ready);
    end
    @(negedge clk);  // cycle 1
    req_valid = 4'b0000;
    tests_run++;
    if (m_i2c_en !== 1'b1 || m_device_addr !== 7'h50 || m_data_addr !== 8'h10 ||
        m_write_data !== 8'hA5 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_issue: en=%b dev=%h addr=%h data=%h busy=%b required 1/50/10/a5/1",
               m_i2c_en, m_device_addr, m_data_addr, m_write_data, busy);
    end
    bad = 1'b0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (m_i2c_en !== 1'b0 || m_device_addr !== 7'h50 || m_data_addr !== 8'h10 ||
          m_write_data !== 8'hA5 || req_done !== 4'b0000 || busy !== 1'b1) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL single_wait_stable: en=%b dev=%h done=%b busy=%b required 0/50/0000/1",
               m_i2c_en, m_device_addr, req_done, busy);
    end
    m_done_flag = 1'b1;
    @(negedge clk);
    m_done_flag = 1'b0;
    tests_run++;
    if (req_done !== 4'b0100 || req_err !== 4'b0000) begin
      tests_failed++; $display("FAIL single_done: done=%b err=%b required 0100/0000", req_done, req_err);
    end
    @(negedge clk);
    tests_run++;
    if (req_done !== 4'b0000 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_idle: done=%b busy=%b required 0000/0", req_done, busy);
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_fields(i, 7'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i));
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp = 4'b0001 << (t % N);
      #1;
      tests_run++;
      if (req_ready !== exp) begin
        tests_failed++; $display("FAIL rr_ready[%0d]: got %b required %b", t, req_ready, exp);
      end
      @(negedge clk);  // cycle 1
      tests_run++;
      if (m_i2c_en !== 1'b1 || m_device_addr !== 7'(8'h10 + t % N) || m_write_data !== 8'(8'h30 + t % N)) begin
        tests_failed++;
        $display("FAIL rr_issue[%0d]: en=%b dev=%h data=%h required 1/%h/%h", t, m_i2c_en,
                 m_device_addr, m_write_data, 7'(8'h10 + t % N), 8'(8'h30 + t % N));
      end
      repeat (9) @(negedge clk);
      m_done_flag = 1'b1;
      @(negedge clk);
      m_done_flag = 1'b0;
      tests_run++;
      if (req_done !== exp) begin
        tests_failed++; $display("FAIL rr_done[%0d]: got %b required %b", t, req_done, exp);
      end
      @(negedge clk);  // back in IDLE
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_withdraw;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0011;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++; $display("FAIL wd_first_ready: got %b required 0001", req_ready);
    end
    @(negedge clk);  // cycle 1
    req_valid = 4'b0010;
    @(negedge clk);  // cycle 2, WAIT
    tests_run++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL wd_wait_ready: ready=%b busy=%b required 0000/1", req_ready, busy);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    m_done_flag = 1'b1;
    @(negedge clk);  // DONE
    m_done_flag = 1'b0;
    req_valid = 4'b1000;
    #1;
    tests_run++;
    if (req_ready !== 4'b0000 || req_done !== 4'b0001) begin
      tests_failed++; $display("FAIL wd_done_cycle: ready=%b done=%b required 0000/0001", req_ready, req_done);
    end
    @(negedge clk);  // IDLE
    tests_run++;
    if (req_ready !== 4'b1000) begin
      tests_failed++; $display("FAIL wd_late_grant: got %b required 1000", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    tests_run++;
    if (m_i2c_en !== 1'b1 || m_device_addr !== 7'h13) begin
      tests_failed++; $display("FAIL wd_late_issue: en=%b dev=%h required 1/13", m_i2c_en, m_device_addr);
    end
    @(negedge clk);
    m_done_flag = 1'b1;
    @(negedge clk);
    m_done_flag = 1'b0;
    tests_run++;
    if (req_done !== 4'b1000) begin
      tests_failed++; $display("FAIL wd_late_done: got %b required 1000", req_done);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    // Complete one transaction for requester 1 so ptr moves to 2.
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    m_done_flag = 1'b1;
    @(negedge clk);
    m_done_flag = 1'b0;
    @(negedge clk);  // IDLE, ptr = 2
    req_valid = 4'b0110;
    #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++; $display("FAIL mr_ptr_before: got %b required 0100", req_ready);
    end
    req_valid = 4'b0100;
    @(negedge clk);  // cycle 1
    req_valid = 4'b0000;
    @(negedge clk);  // cycle 2, WAIT
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || m_i2c_en !== 1'b0 || req_done !== 4'b0000 || m_device_addr !== 7'h00) begin
      tests_failed++;
      $display("FAIL mr_after_reset: busy=%b en=%b done=%b dev=%h required 0/0/0000/00", busy, m_i2c_en, req_done, m_device_addr);
    end
    rst = 1'b0;
    m_done_flag = 1'b1;  // must be ignored in IDLE and ISSUE
    req_valid = 4'b0110;
    #1;
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++; $display("FAIL mr_ptr_cleared: got %b required 0010", req_ready);
    end
    @(negedge clk);  // cycle 1
    req_valid = 4'b0000;
    tests_run++;
    if (m_i2c_en !== 1'b1 || m_device_addr !== 7'h11 || req_done !== 4'b0000) begin
      tests_failed++; $display("FAIL mr_issue: en=%b dev=%h done=%b required 1/11/0000", m_i2c_en, m_device_addr, req_done);
    end
    @(negedge clk);  // cycle 2
    m_done_flag = 1'b0;
    @(negedge clk);  // cycle 3
    tests_run++;
    if (busy !== 1'b1 || req_done !== 4'b0000) begin
      tests_failed++; $display("FAIL mr_done_ignored: busy=%b done=%b required 1/0000", busy, req_done);
    end
    m_done_flag = 1'b1;
    @(negedge clk);
    m_done_flag = 1'b0;
    tests_run++;
    if (req_done !== 4'b0010) begin
      tests_failed++; $display("FAIL mr_done: got %b required 0010", req_done);
    end
    @(negedge clk);
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic bad;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);  // cycle 1
    req_valid = 4'b0100;
    bad = 1'b0;
    for (int c = 2; c < 18; c++) begin
      @(negedge clk);
      if (req_done !== 4'b0000 || req_err !== 4'b0000) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL to_early: done=%b err=%b required 0000/0000", req_done, req_err);
    end
    @(negedge clk);  // cycle 18
    tests_run++;
    if (req_done !== 4'b0001 || req_err !== 4'b0001) begin
      tests_failed++; $display("FAIL to_fire: done=%b err=%b required 0001/0001", req_done, req_err);
    end
    @(negedge clk);  // IDLE
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++; $display("FAIL to_next: got %b required 0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    m_done_flag = 1'b1;
    @(negedge clk);
    m_done_flag = 1'b0;
    tests_run++;
    if (req_done !== 4'b0100 || req_err !== 4'b0000) begin
      tests_failed++; $display("FAIL to_next_done: done=%b err=%b required 0100/0000", req_done, req_err);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    m_done_flag = 1'b0;
    req_dev_addr = '0;
    req_data_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) set_fields(i, 7'(8'h60 + i), 8'(8'h70 + i), 8'(8'h80 + i));
    test_reset;
    test_single;
    test_round_robin;
    test_withdraw;
    test_mid_reset;
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
